// File: rtl/out_deser_pkg.sv
// Shared widths, default capture state code and capture FSM encodings
// for the output deserializer.
package out_deser_pkg;

  localparam int BYTE_W  = 8;
  localparam int TAG_W   = 8;
  localparam int CS_W    = 3;
  localparam int ENTRY_W = TAG_W + BYTE_W;

  localparam logic [CS_W-1:0] CAP_CS_DEF = 3'b001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/out_fifo.sv
// Small FIFO holding {tag, byte} entries. The head entry is kept in an
// output register so it appears one cycle after the push that fills an
// empty FIFO, and holds its last value once the FIFO drains.
module out_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rd_nx;
  logic [LW-1:0]    lvl_q;
  logic [LW-1:0]    lvl_nx;
  logic [WIDTH-1:0] head_q;
  logic             ovf_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (lvl_q == LW'(DEPTH));
  assign empty   = (lvl_q == '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nx   = do_pop ? rd_q + AW'(1) : rd_q;
  assign lvl_nx  = lvl_q + LW'(do_push) - LW'(do_pop);

  assign rdata = head_q;
  assign level = lvl_q;
  assign ovf   = ovf_q;

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

  // Pointers, occupancy, sticky overflow and the registered head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      rd_q  <= rd_nx;
      lvl_q <= lvl_nx;
      if (push && full && !do_pop) ovf_q <= 1'b1;
      // The new head bypasses storage when it is the entry being written now.
      if (lvl_nx != '0)
        head_q <= (do_push && (wr_q == rd_nx)) ? wdata : mem[rd_nx];
    end
  end

endmodule

// File: rtl/out_deser.sv
// Output deserializer: assembles the serial cal-stage bit stream into
// MSB-first bytes while cs equals CAP_CS, tags each byte with the state
// counter sampled on its last bit, and queues {tag, byte} in a FIFO.
module out_deser
  import out_deser_pkg::*;
#(
  parameter logic [CS_W-1:0] CAP_CS = CAP_CS_DEF,
  parameter int              DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din,
  input  logic [CS_W-1:0]              cs,
  input  logic [TAG_W-1:0]             count,
  output logic [BYTE_W-1:0]            data,
  output logic [TAG_W-1:0]             tag,
  output logic                         valid,
  input  logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf
);

  cap_state_t           state_q;
  logic [2:0]           bitcnt_q;
  logic [BYTE_W-2:0]    shreg_q;
  logic                 cap_hit;
  logic                 vld_p0;
  logic [ENTRY_W-1:0]   entry_p0;
  logic [ENTRY_W-1:0]   head;
  logic                 empty;

  assign cap_hit  = (cs == CAP_CS);
  // The edge that samples the 8th bit pushes the completed byte directly.
  assign vld_p0   = (state_q == ST_SHIFT) && cap_hit && (bitcnt_q == 3'd7);
  assign entry_p0 = {count, shreg_q, din};

  // Capture FSM: IDLE waits for the capture code, SHIFT gathers bits and
  // wraps straight into the next byte without a gap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cap_hit) begin
            state_q  <= ST_SHIFT;
            shreg_q  <= {{(BYTE_W-2){1'b0}}, din};
            bitcnt_q <= 3'd1;
          end
        end
        ST_SHIFT: begin
          if (!cap_hit) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
          end else if (bitcnt_q == 3'd7) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
          end else begin
            shreg_q  <= {shreg_q[BYTE_W-3:0], din};
            bitcnt_q <= bitcnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p0),
    .wdata (entry_p0),
    .pop   (ready),
    .rdata (head),
    .full  (),
    .empty (empty),
    .level (level),
    .ovf   (ovf)
  );

  assign valid = !empty;
  assign data  = head[BYTE_W-1:0];
  assign tag   = head[ENTRY_W-1:BYTE_W];

endmodule

// File: tb/tb_out_deser.sv
// Directed bench for out_deser: a vector table for the basic capture and
// pop/underflow behaviour, plus hand-written multi-cycle sequences.
module tb_out_deser;

  logic       clk;
  logic       rst;
  logic       din;
  logic [2:0] cs;
  logic [7:0] count;
  logic [7:0] data;
  logic [7:0] tag;
  logic       valid;
  logic       ready;
  logic [2:0] level;
  logic       ovf;

  int n_chk  = 0;
  int n_fail = 0;

  out_deser dut (
    .clk   (clk),
    .reset (rst),
    .din   (din),
    .cs    (cs),
    .count (count),
    .data  (data),
    .tag   (tag),
    .valid (valid),
    .ready (ready),
    .level (level),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [2:0] c;
    logic       d;
    logic [7:0] n;
    logic       y;
    logic       ev;
    logic [7:0] ed;
    logic [7:0] et;
    logic [2:0] el;
    logic       eo;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r, input logic [2:0] c, input logic d,
                              input logic [7:0] n, input logic y, input logic ev,
                              input logic [7:0] ed, input logic [7:0] et,
                              input logic [2:0] el, input logic eo);
    vec_t v;
    v.r = r; v.c = c; v.d = d; v.n = n; v.y = y;
    v.ev = ev; v.ed = ed; v.et = et; v.el = el; v.eo = eo;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [7:0] ed,
                         input logic [7:0] et, input logic [2:0] el, input logic eo);
    chk({nm, ".valid"}, {7'd0, valid}, {7'd0, ev});
    chk({nm, ".data"},  data, ed);
    chk({nm, ".tag"},   tag, et);
    chk({nm, ".level"}, {5'd0, level}, {5'd0, el});
    chk({nm, ".ovf"},   {7'd0, ovf}, {7'd0, eo});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; cs = 3'b000; din = 1'b0; count = 8'h00; ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic idle();
    cs = 3'b000; din = 1'b0;
    tick();
  endtask

  // Eight capture cycles, MSB first; count carries t only on the last bit.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] t, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      cs    = 3'b001;
      din   = b[7-i];
      count = (i == 7) ? t : 8'hEE;
      if (i == 7 && rdy_last) ready = 1'b1;
      tick();
    end
    if (rdy_last) ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;

    // Reset rows drive cs=CAP_CS and ready=1 to show reset wins.
    for (int i = 0; i < 5; i++)
      tbl[i] = mk(1'b1, 3'b001, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[5]  = mk(1'b0, 3'b001, 1'b1, 8'h09, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[6]  = mk(1'b0, 3'b001, 1'b0, 8'h0A, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[7]  = mk(1'b0, 3'b001, 1'b1, 8'h0B, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[8]  = mk(1'b0, 3'b001, 1'b0, 8'h0C, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[9]  = mk(1'b0, 3'b001, 1'b0, 8'h0D, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[10] = mk(1'b0, 3'b001, 1'b1, 8'h0E, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[11] = mk(1'b0, 3'b001, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    tbl[12] = mk(1'b0, 3'b001, 1'b1, 8'h10, 1'b0, 1'b1, 8'hA5, 8'h10, 3'd1, 1'b0);
    tbl[13] = mk(1'b0, 3'b000, 1'b0, 8'h11, 1'b0, 1'b1, 8'hA5, 8'h10, 3'd1, 1'b0);
    tbl[14] = mk(1'b0, 3'b000, 1'b0, 8'h12, 1'b1, 1'b0, 8'hA5, 8'h10, 3'd0, 1'b0);
    tbl[15] = mk(1'b0, 3'b000, 1'b0, 8'h13, 1'b1, 1'b0, 8'hA5, 8'h10, 3'd0, 1'b0);
    tbl[16] = mk(1'b0, 3'b010, 1'b1, 8'h14, 1'b0, 1'b0, 8'hA5, 8'h10, 3'd0, 1'b0);
    tbl[17] = mk(1'b0, 3'b000, 1'b0, 8'h15, 1'b0, 1'b0, 8'hA5, 8'h10, 3'd0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].r; cs = tbl[i].c; din = tbl[i].d; count = tbl[i].n; ready = tbl[i].y;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].et, tbl[i].el, tbl[i].eo);
    end

    // Partial byte aborted by cs leaving the capture code is discarded.
    do_reset(2);
    cs = 3'b001;
    for (int i = 0; i < 5; i++) begin
      din = i[0];
      tick();
    end
    idle(); idle();
    chk_all("abort", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    send_byte(8'hFF, 8'h20, 1'b0);
    idle();
    chk_all("abort_ff", 1'b1, 8'hFF, 8'h20, 3'd1, 1'b0);
    ready = 1'b1;
    idle();
    ready = 1'b0;
    chk_all("abort_one", 1'b0, 8'hFF, 8'h20, 3'd0, 1'b0);

    // Overflow: five bytes into a four-entry FIFO with no consumer.
    do_reset(2);
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 8'(8'h30 + k), 1'b0);
      if (k == 4) chk_all("ovf_pre", 1'b1, 8'h01, 8'h31, 3'd4, 1'b0);
    end
    idle();
    chk_all("ovf_set", 1'b1, 8'h01, 8'h31, 3'd4, 1'b1);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d.data", k), data, 8'(k));
      chk($sformatf("drain%0d.tag", k), tag, 8'(8'h30 + k));
      idle();
    end
    ready = 1'b0;
    chk_all("drained", 1'b0, 8'h04, 8'h34, 3'd0, 1'b1);

    // Full FIFO: push and pop on the same edge both succeed.
    do_reset(2);
    send_byte(8'h11, 8'h41, 1'b0);
    send_byte(8'h22, 8'h42, 1'b0);
    send_byte(8'h33, 8'h43, 1'b0);
    send_byte(8'h44, 8'h44, 1'b0);
    chk_all("full", 1'b1, 8'h11, 8'h41, 3'd4, 1'b0);
    send_byte(8'h55, 8'h45, 1'b1);
    idle();
    chk_all("full_pp", 1'b1, 8'h22, 8'h42, 3'd4, 1'b0);
    ready = 1'b1;
    pat = 16'h2233;
    chk("pp_d0", data, 8'h22); idle();
    chk("pp_d1", data, 8'h33); idle();
    chk("pp_d2", data, 8'h44); idle();
    chk("pp_d3", data, 8'h55);
    chk("pp_t3", tag, 8'h45);  idle();
    ready = 1'b0;
    chk_all("pp_empty", 1'b0, 8'h55, 8'h45, 3'd0, 1'b0);

    // Reset mid-byte with two entries queued and ovf already set.
    do_reset(2);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 8'(8'h50 + k), 1'b0);
    ready = 1'b1;
    idle(); idle();
    ready = 1'b0;
    idle();
    chk_all("pre_rst", 1'b1, 8'h03, 8'h53, 3'd2, 1'b1);
    cs = 3'b001;
    for (int i = 0; i < 3; i++) begin
      din = pat[i];
      tick();
    end
    rst = 1'b1; din = 1'b1; ready = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    chk_all("mid_rst", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    send_byte(8'h3C, 8'h60, 1'b0);
    idle();
    chk_all("post_rst", 1'b1, 8'h3C, 8'h60, 3'd1, 1'b0);

    // Sixteen continuous capture cycles: back-to-back bytes, no gap.
    do_reset(2);
    ready = 1'b1;
    pat = 16'hC35A;
    for (int i = 0; i < 16; i++) begin
      cs = 3'b001; din = pat[15-i]; count = 8'(i + 1);
      tick();
      if (i == 6)  chk_all("b2b_e7",  1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      if (i == 7)  chk_all("b2b_e8",  1'b1, 8'hC3, 8'h08, 3'd1, 1'b0);
      if (i == 8)  chk_all("b2b_e9",  1'b0, 8'hC3, 8'h08, 3'd0, 1'b0);
      if (i == 15) chk_all("b2b_e16", 1'b1, 8'h5A, 8'h10, 3'd1, 1'b0);
    end
    idle();
    chk_all("b2b_end", 1'b0, 8'h5A, 8'h10, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
